encrypter_in: RTL and testbench
===============================

Name: encrypter_in

Overview:
- Front end of the encryption path.
- Takes plaintext bytes from the UART receiver and serialises them LSB-first into one bit stream.
- Cuts the stream into packs of (n_len-1) bits, where n_len is the bit length of n_key, zero-pads each pack to a 32-bit word and hands it to FastModExp.
- Flags the final word so the decrypt-side unpacker knows where the message ends.

Parameters:
- TIMEOUT_CYCLES, 100000000: idle cycles after the last received byte before an automatic message end. Used only with IDLE_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse: latch n_key and begin a message
- n_key  in  32  RSA modulus
- rx_done_tick  in  1  one-cycle strobe: rx_data valid
- rx_data  in  8  received byte
- msg_end  in  1  pulse: no more bytes for this message
- fme_ready  in  1  FastModExp idle and able to accept a word
- word_valid  out  1  one-cycle strobe: word_out is a pack for FME
- word_out  out  32  zero-padded pack
- last_word_tick  out  1  pulse coincident with word_valid of the final word
- overrun  out  1  sticky: a byte arrived while the byte buffer was full
- key_err  out  1  pulse: n_key < 2, message aborted
- done_tick  out  1  pulse: final word issued, block back in IDLE

Behaviour:
- Reset values: every output 0; word_out 0; state IDLE; all counters and buffers 0; end_pending 0.
- Registers:
  - key_buf[31:0], n_len[5:0] (6 bits so that n_key bit31=1 gives n_len=32)
  - pack[31:0], pack_cnt[5:0]
  - byte_buf[7:0], bit_cnt[3:0], byte_full
  - end_pending
- Byte capture, active in every state except IDLE and SIZING:
  - rx_done_tick with byte_full=0 loads byte_buf and sets byte_full.
  - rx_done_tick with byte_full=1 drops the byte and sets overrun. overrun clears only on rst or start.
- msg_end in any non-IDLE state sets end_pending.
- IDLE:
  - Continuously loads key_buf<=n_key and n_len<=0.
  - start: go to SIZING; clear overrun, end_pending, pack, pack_cnt.
- SIZING: one cycle per bit. While key_buf!=0: n_len+=1, key_buf>>=1. When key_buf==0:
  - n_len<2: pulse key_err, go to IDLE.
  - otherwise: go to COLLECT.
- COLLECT:
  - byte_full=1: go to SHIFT with bit_cnt=0.
  - byte_full=0 and end_pending=1: go to FLUSH.
- SHIFT: one bit per cycle. pack[pack_cnt]<=byte_buf[0]; byte_buf>>=1; pack_cnt+=1; bit_cnt+=1.
  - Pack filled this cycle (pack_cnt==n_len-2 before the increment): go to EMIT. bit_cnt is preserved.
  - Else, bit_cnt==7 this cycle: clear byte_full, return to COLLECT.
  - When EMIT is entered on the 8th bit, byte_full is cleared on exit from EMIT.
- EMIT:
  - Waits for fme_ready=1, then for one cycle: word_out<=pack, word_valid=1, pack<=0, pack_cnt<=0.
  - Next state: SHIFT if byte bits remain, else COLLECT.
  - Bits above n_len-2 of word_out are always 0.
- FLUSH:
  - Waits for fme_ready, then issues word_valid with word_out=pack (partial or all zero) and last_word_tick=1.
  - Same cycle: done_tick=1, go to IDLE.
  - An empty pack at message end still yields one all-zero final word. A zero-byte message yields exactly one zero word.
- Latency: first bit of a byte enters the pack 2 cycles after rx_done_tick while in COLLECT.
- Simultaneous events:
  - rx_done_tick and msg_end in the same cycle: the byte is accepted, then end is processed after it.
  - rx_done_tick in the same cycle byte_full clears: treated as byte_full=1 (overrun). Lossless operation needs UART byte period > 8+EMIT wait cycles, which holds for baud ≤ clk/100.
- start outside IDLE: ignored.
- rst mid-message: immediate return to IDLE; no word or tick emitted.

Optional Feature:
- Macro IDLE_TIMEOUT_EN.
- Defined:
  - A 27-bit counter runs in COLLECT while byte_full=0 and at least one byte has been received this message.
  - The counter resets on every rx_done_tick.
  - Reaching TIMEOUT_CYCLES sets end_pending, exactly as a msg_end pulse.
- Undefined: no counter; the message ends only via msg_end.

Test Plan:
- n_key=0x000000FF, start, byte 0x41, msg_end, fme_ready=1 -> n_len=8; word 0x00000041; then final word 0x00000000 with last_word_tick and done_tick.
- n_key=0x0000FFFF, bytes 0xB4 then 0x92, msg_end -> word 0x000012B4; final word 0x00000001 with last_word_tick.
- n_key=0x00000001 or 0x00000000, start -> key_err pulse, no word_valid, back in IDLE.
- n_key=0x000000FF, fme_ready held 0 for 50 cycles, then a second rx_done_tick while the first byte is unconsumed -> overrun=1; after fme_ready=1 the first word is still 0x00000041.
- start, immediate msg_end -> exactly one word_valid, word_out=0, with last_word_tick and done_tick.
- With IDLE_TIMEOUT_EN, TIMEOUT_CYCLES=20, n_key=0xFF, byte 0x41, no msg_end -> final zero word with last_word_tick about 20 cycles after the last shift.

Source files
------------

// File: rtl/encrypter_in.sv
// Encryption front end: serialises received bytes LSB-first into (n_len-1)-bit packs for FastModExp.
// Optional macro IDLE_TIMEOUT_EN adds an automatic message end after TIMEOUT_CYCLES idle cycles.
module encrypter_in #(
   parameter int TIMEOUT_CYCLES = 100000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] n_key,
   input  logic        rx_done_tick,
   input  logic [7:0]  rx_data,
   input  logic        msg_end,
   input  logic        fme_ready,
   output logic        word_valid,
   output logic [31:0] word_out,
   output logic        last_word_tick,
   output logic        overrun,
   output logic        key_err,
   output logic        done_tick
);
   typedef enum logic [2:0] {
      S_IDLE, S_SIZING, S_COLLECT, S_SHIFT, S_EMIT, S_FLUSH
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] key_buf_q, key_buf_d;
   logic [5:0]  n_len_q, n_len_d;
   logic [31:0] pack_q, pack_d;
   logic [5:0]  pack_cnt_q, pack_cnt_d;
   logic [7:0]  byte_buf_q, byte_buf_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic        byte_full_q, byte_full_d;
   logic        end_pending_q, end_pending_d;
   logic        overrun_q, overrun_d;
   logic        word_valid_q, word_valid_d;
   logic [31:0] word_out_q, word_out_d;
   logic        last_q, last_d;
   logic        key_err_q, key_err_d;
   logic        done_q, done_d;
   logic        capture_en;
   logic        tmo_hit;

   assign capture_en = (state_q != S_IDLE) && (state_q != S_SIZING);

`ifdef IDLE_TIMEOUT_EN
   localparam logic [26:0] TMO_LIMIT = 27'(TIMEOUT_CYCLES);
   logic [26:0] tmo_cnt_q;
   logic        got_byte_q;

   // Counts only while waiting on the next byte once the message has started flowing.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q  <= '0;
         got_byte_q <= 1'b0;
      end else if (state_q == S_IDLE && start) begin
         tmo_cnt_q  <= '0;
         got_byte_q <= 1'b0;
      end else if (capture_en && rx_done_tick) begin
         tmo_cnt_q  <= '0;
         got_byte_q <= 1'b1;
      end else if (state_q == S_COLLECT && !byte_full_q && got_byte_q && !tmo_hit) begin
         tmo_cnt_q  <= tmo_cnt_q + 27'd1;
      end
   end

   assign tmo_hit = got_byte_q && (tmo_cnt_q == TMO_LIMIT);
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYCLES;
   assign tmo_hit    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         key_buf_q     <= '0;
         n_len_q       <= '0;
         pack_q        <= '0;
         pack_cnt_q    <= '0;
         byte_buf_q    <= '0;
         bit_cnt_q     <= '0;
         byte_full_q   <= 1'b0;
         end_pending_q <= 1'b0;
         overrun_q     <= 1'b0;
         word_valid_q  <= 1'b0;
         word_out_q    <= '0;
         last_q        <= 1'b0;
         key_err_q     <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         key_buf_q     <= key_buf_d;
         n_len_q       <= n_len_d;
         pack_q        <= pack_d;
         pack_cnt_q    <= pack_cnt_d;
         byte_buf_q    <= byte_buf_d;
         bit_cnt_q     <= bit_cnt_d;
         byte_full_q   <= byte_full_d;
         end_pending_q <= end_pending_d;
         overrun_q     <= overrun_d;
         word_valid_q  <= word_valid_d;
         word_out_q    <= word_out_d;
         last_q        <= last_d;
         key_err_q     <= key_err_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      key_buf_d     = key_buf_q;
      n_len_d       = n_len_q;
      pack_d        = pack_q;
      pack_cnt_d    = pack_cnt_q;
      byte_buf_d    = byte_buf_q;
      bit_cnt_d     = bit_cnt_q;
      byte_full_d   = byte_full_q;
      end_pending_d = end_pending_q;
      overrun_d     = overrun_q;
      word_valid_d  = 1'b0;
      word_out_d    = word_out_q;
      last_d        = 1'b0;
      key_err_d     = 1'b0;
      done_d        = 1'b0;

      // Single-byte buffer; a byte landing on a full buffer is lost.
      if (capture_en && rx_done_tick) begin
         if (byte_full_q) begin
            overrun_d = 1'b1;
         end else begin
            byte_buf_d  = rx_data;
            byte_full_d = 1'b1;
         end
      end
      if (state_q != S_IDLE && (msg_end || tmo_hit)) end_pending_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            key_buf_d = n_key;
            n_len_d   = '0;
            if (start) begin
               state_d       = S_SIZING;
               overrun_d     = 1'b0;
               end_pending_d = 1'b0;
               pack_d        = '0;
               pack_cnt_d    = '0;
               // Drop any byte left over from a previous message.
               byte_full_d   = 1'b0;
               bit_cnt_d     = '0;
            end
         end
         S_SIZING: begin
            if (key_buf_q != 32'd0) begin
               n_len_d   = n_len_q + 6'd1;
               key_buf_d = key_buf_q >> 1;
            end else if (n_len_q < 6'd2) begin
               key_err_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               state_d   = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (byte_full_q) begin
               state_d   = S_SHIFT;
               bit_cnt_d = '0;
            end else if (end_pending_q) begin
               state_d   = S_FLUSH;
            end
         end
         S_SHIFT: begin
            pack_d[pack_cnt_q[4:0]] = byte_buf_q[0];
            byte_buf_d = byte_buf_q >> 1;
            pack_cnt_d = pack_cnt_q + 6'd1;
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (pack_cnt_q == n_len_q - 6'd2) begin
               state_d = S_EMIT;
            end else if (bit_cnt_q == 4'd7) begin
               byte_full_d = 1'b0;
               state_d     = S_COLLECT;
            end
         end
         S_EMIT: begin
            if (fme_ready) begin
               word_out_d   = pack_q;
               word_valid_d = 1'b1;
               pack_d       = '0;
               pack_cnt_d   = '0;
               // bit_cnt==8 means the pack closed on the byte's last bit.
               if (bit_cnt_q == 4'd8) begin
                  byte_full_d = 1'b0;
                  state_d     = S_COLLECT;
               end else begin
                  state_d     = S_SHIFT;
               end
            end
         end
         S_FLUSH: begin
            if (fme_ready) begin
               word_out_d   = pack_q;
               word_valid_d = 1'b1;
               last_d       = 1'b1;
               done_d       = 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign word_valid     = word_valid_q;
   assign word_out       = word_out_q;
   assign last_word_tick = last_q;
   assign overrun        = overrun_q;
   assign key_err        = key_err_q;
   assign done_tick      = done_q;
endmodule

// File: tb/tb_encrypter_in.sv
// Self-checking bench for encrypter_in: random messages against a bit-stream packing model.
module tb_encrypter_in;
   logic        clk = 1'b0;
   logic        rst, start, rx_done_tick, msg_end, fme_ready;
   logic [31:0] n_key;
   logic [7:0]  rx_data;
   logic        word_valid, last_word_tick, overrun, key_err, done_tick;
   logic [31:0] word_out;

   int vec = 0, errs = 0;
   int done_cnt = 0, key_err_cnt = 0;
   int rdy_mode = 1;
   logic [31:0] exp_w[$];
   bit          exp_l[$];
   logic [31:0] obs[$];

   encrypter_in #(.TIMEOUT_CYCLES(1000)) dut (
      .clk(clk), .rst(rst), .start(start), .n_key(n_key),
      .rx_done_tick(rx_done_tick), .rx_data(rx_data), .msg_end(msg_end),
      .fme_ready(fme_ready), .word_valid(word_valid), .word_out(word_out),
      .last_word_tick(last_word_tick), .overrun(overrun), .key_err(key_err),
      .done_tick(done_tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       fme_ready = 1'b0;
         1:       fme_ready = 1'b1;
         default: fme_ready = ($urandom_range(3) != 0);
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vec++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got %h want %h", name, act, expv);
      end
   endtask

   function automatic int bitlen(input logic [31:0] k);
      int l = 0;
      for (int i = 0; i < 32; i++) if (k[i]) l = i + 1;
      return l;
   endfunction

   // Reference: concatenate bytes LSB-first, cut into (len-1)-bit words, final word is the remainder.
   function automatic void model(input logic [31:0] key, input byte unsigned bq[$]);
      int p, k;
      logic [31:0] w;
      if (bitlen(key) < 2) return;
      p = bitlen(key) - 1;
      k = 0;
      w = '0;
      foreach (bq[i]) begin
         for (int b = 0; b < 8; b++) begin
            w[k] = bq[i][b];
            k++;
            if (k == p) begin
               exp_w.push_back(w); exp_l.push_back(1'b0);
               w = '0; k = 0;
            end
         end
      end
      exp_w.push_back(w); exp_l.push_back(1'b1);
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (key_err) key_err_cnt++;
         if (done_tick) done_cnt++;
         if (word_valid || last_word_tick || done_tick) begin
            if (exp_w.size() == 0) begin
               chk("spurious_word", {31'd0, word_valid}, 32'd0);
            end else begin
               logic [31:0] ew;
               bit el;
               ew = exp_w.pop_front();
               el = exp_l.pop_front();
               obs.push_back(word_out);
               chk("word_out", word_out, ew);
               chk("strobes", {29'd0, word_valid, last_word_tick, done_tick}, {29'd0, 1'b1, el, el});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_end();
      msg_end = 1'b1; tick(); msg_end = 1'b0;
   endtask

   task automatic send(input byte unsigned b);
      rx_data = b; rx_done_tick = 1'b1; tick(); rx_done_tick = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int c0 = done_cnt;
      int n = 0;
      while (done_cnt == c0 && n < bound) begin
         tick(); n++;
      end
      chk("done_seen", {31'd0, done_cnt != c0}, 32'd1);
   endtask

   task automatic run_msg(input logic [31:0] key, input byte unsigned bq[$], input int gap);
      int ke = key_err_cnt;
      model(key, bq);
      n_key = key;
      pulse_start();
      repeat (40) tick();
      if (bitlen(key) < 2) begin
         chk("key_err", key_err_cnt - ke, 32'd1);
         return;
      end
      foreach (bq[i]) begin
         send(bq[i]);
         repeat (gap) tick();
      end
      pulse_end();
      wait_done(3000);
      chk("drained", exp_w.size(), 32'd0);
   endtask

   initial begin
      byte unsigned q[$];
      rst = 1'b1; start = 1'b0; rx_done_tick = 1'b0; msg_end = 1'b0;
      n_key = '0; rx_data = '0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_outs", {26'd0, word_valid, last_word_tick, overrun, key_err, done_tick, 1'b0}, 32'd0);
      chk("rst_word", word_out, 32'd0);

      // Hand-computed: 0x41 with 7-bit packs -> 0x41 then remainder 0.
      obs.delete();
      q = '{8'h41};
      run_msg(32'h0000_00FF, q, 20);
      chk("t1_cnt", obs.size(), 32'd2);
      if (obs.size() == 2) begin
         chk("t1_w0", obs[0], 32'h0000_0041);
         chk("t1_w1", obs[1], 32'h0000_0000);
      end

      // 0x92B4 with 15-bit packs -> 0x12B4 then remainder 1.
      obs.delete();
      q = '{8'hB4, 8'h92};
      run_msg(32'h0000_FFFF, q, 20);
      chk("t2_cnt", obs.size(), 32'd2);
      if (obs.size() == 2) begin
         chk("t2_w0", obs[0], 32'h0000_12B4);
         chk("t2_w1", obs[1], 32'h0000_0001);
      end

      obs.delete();
      run_msg(32'h0000_0001, q, 20);
      run_msg(32'h0000_0000, q, 20);
      chk("keyerr_nowords", obs.size(), 32'd0);

      // Stall FME so the first byte is still held when a second arrives.
      obs.delete();
      rdy_mode = 0;
      q = '{8'h41};
      model(32'h0000_00FF, q);
      n_key = 32'h0000_00FF;
      pulse_start();
      repeat (40) tick();
      send(8'h41);
      repeat (50) tick();
      send(8'hAA);
      @(negedge clk);
      chk("overrun_set", {31'd0, overrun}, 32'd1);
      #1 rdy_mode = 1;
      repeat (20) tick();
      pulse_end();
      wait_done(500);
      chk("ovr_cnt", obs.size(), 32'd2);
      if (obs.size() == 2) chk("ovr_w0", obs[0], 32'h0000_0041);

      // Immediate end: one all-zero final word.
      obs.delete();
      q.delete();
      model(32'h0000_00FF, q);
      n_key = 32'h0000_00FF;
      pulse_start();
      pulse_end();
      wait_done(500);
      chk("empty_cnt", obs.size(), 32'd1);
      if (obs.size() == 1) chk("empty_w", obs[0], 32'd0);
      chk("overrun_clr", {31'd0, overrun}, 32'd0);

      rdy_mode = 2;
      for (int m = 0; m < 20; m++) begin
         int L, nb;
         logic [63:0] msk;
         logic [31:0] key;
         L   = $urandom_range(32, 2);
         msk = (64'd1 << L) - 64'd1;
         key = ($urandom & msk[31:0]) | (32'd1 << (L - 1));
         nb  = $urandom_range(6, 0);
         q.delete();
         for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
         run_msg(key, q, 150);
         chk("rand_no_overrun", {31'd0, overrun}, 32'd0);
      end
      rdy_mode = 1;

`ifdef IDLE_TIMEOUT_EN
      obs.delete();
      q = '{8'h41};
      model(32'h0000_00FF, q);
      n_key = 32'h0000_00FF;
      pulse_start();
      repeat (40) tick();
      send(8'h41);
      wait_done(3000);
      chk("tmo_cnt", obs.size(), 32'd2);
`endif

      repeat (5) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
